// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: serialises a 3-byte payload plus terminator as 8N1 UART frames.
// Optional checksum byte enabled by UART_PKT_TX_CHECKSUM_EN.
module uart_pkt_tx #(
   parameter int         CLK_HZ    = 27000000,
   parameter int         BIT_RATE  = 115200,
   parameter logic [7:0] TERM_BYTE = 8'h0A
) (
   input  logic        clk,
   input  logic        reset_uart,
   input  logic [23:0] s_payload,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        uart_txd,
   output logic        busy,
   output logic        pkt_done
);

   localparam int CPB = CLK_HZ / BIT_RATE;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CPB - 1);
`ifdef UART_PKT_TX_CHECKSUM_EN
   localparam logic [2:0] LAST = 3'd4;
`else
   localparam logic [2:0] LAST = 3'd3;
`endif

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [2:0]      byte_idx;
   logic [23:0]     payload;
   logic [7:0]      cur_byte;
   logic            bit_end;
   logic            txd_q;
   logic            done_q;

   assign bit_end  = (baud_cnt == '0);
   assign s_ready  = (state == IDLE);
   assign busy     = ~s_ready;
   assign uart_txd = txd_q;
   assign pkt_done = done_q;

   // Select the byte currently on the wire from the captured payload.
   always_comb begin
      cur_byte = TERM_BYTE;
      case (byte_idx)
         3'd0: cur_byte = payload[23:16];
         3'd1: cur_byte = payload[15:8];
         3'd2: cur_byte = payload[7:0];
`ifdef UART_PKT_TX_CHECKSUM_EN
         3'd3: cur_byte = payload[23:16] ^ payload[15:8] ^ payload[7:0];
`endif
         default: cur_byte = TERM_BYTE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset_uart) begin
      if (reset_uart) state <= IDLE;
      else            state <= state_nx;
   end

   // Next-state logic: bit boundaries advance the frame sequencer.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (s_valid) state_nx = START;
         START: if (bit_end) state_nx = DATA;
         DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
         STOP:  if (bit_end) state_nx = (byte_idx == LAST) ? IDLE : START;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: baud timer, bit/byte indices, payload capture and line register.
   always_ff @(posedge clk or posedge reset_uart) begin
      if (reset_uart) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         payload  <= '0;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            txd_q <= 1'b1;
            if (s_valid) begin
               payload  <= s_payload;
               baud_cnt <= RELOAD;
               bit_idx  <= '0;
               byte_idx <= '0;
               txd_q    <= 1'b0;
            end
         end else if (!bit_end) begin
            baud_cnt <= baud_cnt - CW'(1);
         end else begin
            baud_cnt <= RELOAD;
            case (state)
               START: begin
                  bit_idx <= '0;
                  txd_q   <= cur_byte[0];
               end
               DATA: begin
                  if (bit_idx == 3'd7) begin
                     txd_q <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd_q   <= cur_byte[bit_idx + 3'd1];
                  end
               end
               STOP: begin
                  if (byte_idx == LAST) begin
                     done_q   <= 1'b1;
                     byte_idx <= '0;
                     txd_q    <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     txd_q    <= 1'b0;
                  end
               end
               default: txd_q <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx at default parameters.
// Byte count follows UART_PKT_TX_CHECKSUM_EN.
module tb_uart_pkt_tx;

   localparam int CPB = 27000000 / 115200;
`ifdef UART_PKT_TX_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] s_payload = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, txd, busy, pkt_done;

   int cyc = 0;
   int done_cnt = 0;
   int n_run = 0;
   int n_fail = 0;

   uart_pkt_tx dut (
      .clk(clk), .reset_uart(rst), .s_payload(s_payload),
      .s_valid(s_valid), .s_ready(s_ready), .uart_txd(txd),
      .busy(busy), .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   // Cycle counter and pkt_done pulse counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pkt_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic send(input logic [23:0] p);
      @(negedge clk);
      s_payload = p;
      s_valid   = 1'b1;
      @(negedge clk);
      s_valid   = 1'b0;
   endtask

   // Expected wire bytes; cks is the hand-computed xor of the payload.
   function automatic logic [7:0] exp_byte(input logic [23:0] p,
                                           input logic [7:0] cks, input int i);
      case (i)
         0: return p[23:16];
         1: return p[15:8];
         2: return p[7:0];
         3: return (NB == 5) ? cks : 8'h0A;
         default: return 8'h0A;
      endcase
   endfunction

   // Sample every bit mid-period and check pkt_done latency.
   task automatic recv_pkt(input logic [23:0] p, input logic [7:0] cks,
                           input string tag);
      int c0;
      int g;
      logic [7:0] got;
      g = 0;
      while (txd !== 1'b0 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (txd !== 1'b0) begin
         check({tag, "_nostart"}, 32'(txd), 32'd0);
         return;
      end
      c0 = cyc;
      for (int i = 0; i < NB; i++) begin
         wait_to(c0 + i * 10 * CPB + CPB / 2);
         check($sformatf("%s_start%0d", tag, i), 32'(txd), 32'd0);
         for (int j = 0; j < 8; j++) begin
            wait_to(c0 + (i * 10 + 1 + j) * CPB + CPB / 2);
            got[j] = txd;
         end
         check($sformatf("%s_byte%0d", tag, i), 32'(got),
               32'(exp_byte(p, cks, i)));
         wait_to(c0 + (i * 10 + 9) * CPB + CPB / 2);
         check($sformatf("%s_stop%0d", tag, i), 32'(txd), 32'd1);
      end
      g = 0;
      while (pkt_done !== 1'b1 && g < 2 * CPB) begin
         @(negedge clk);
         g++;
      end
      check({tag, "_done_lat"}, 32'(cyc - c0), 32'(NB * 10 * CPB));
      check({tag, "_ready_at_done"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      int d0;
      int c0;
      logic hi;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_ready", 32'(s_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(pkt_done), 32'd0);

      // Basic packet.
      d0 = done_cnt;
      send(24'h140000);
      check("p1_busy", 32'(busy), 32'd1);
      recv_pkt(24'h140000, 8'h14, "p1");
      @(negedge clk);
      check("p1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("p1_idle_ready", 32'(s_ready), 32'd1);

      // Checksum vector.
      d0 = done_cnt;
      send(24'h5A0F33);
      recv_pkt(24'h5A0F33, 8'h66, "p2");
      @(negedge clk);
      check("p2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Back-to-back with s_valid held high.
      d0 = done_cnt;
      @(negedge clk);
      s_payload = 24'h010203;
      s_valid   = 1'b1;
      @(negedge clk);
      s_payload = 24'hAABBCC;
      recv_pkt(24'h010203, 8'h00, "b1");
      @(negedge clk);
      check("b2b_ready_low", 32'(s_ready), 32'd0);
      check("b2b_start", 32'(txd), 32'd0);
      s_valid = 1'b0;
      recv_pkt(24'hAABBCC, 8'hDD, "b2");
      @(negedge clk);
      check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

      // Payload change during byte1.
      d0 = done_cnt;
      send(24'h123456);
      fork
         recv_pkt(24'h123456, 8'h70, "chg");
         begin
            repeat (15 * CPB) @(negedge clk);
            s_payload = 24'hFFFFFF;
         end
      join
      @(negedge clk);
      check("chg_done_cnt", 32'(done_cnt - d0), 32'd1);

      // s_valid pulse while busy is ignored.
      d0 = done_cnt;
      send(24'h3C5AA5);
      fork
         recv_pkt(24'h3C5AA5, 8'hC3, "ign");
         begin
            repeat (5 * CPB) @(negedge clk);
            s_payload = 24'hFFFFFF;
            s_valid   = 1'b1;
            @(negedge clk);
            s_valid   = 1'b0;
         end
      join
      hi = 1'b1;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (txd !== 1'b1) hi = 1'b0;
      end
      check("ign_line_idle", 32'(hi), 32'd1);
      check("ign_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Reset during byte2 data bits.
      d0 = done_cnt;
      send(24'hABCDEF);
      c0 = cyc;
      wait_to(c0 + 23 * CPB + 50);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_txd", 32'(txd), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(pkt_done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", 32'(s_ready), 32'd1);
      repeat (10 * CPB) @(negedge clk);
      check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      check("rst_mid_line", 32'(txd), 32'd1);
      send(24'h000001);
      recv_pkt(24'h000001, 8'h01, "post");
      @(negedge clk);
      check("post_done_cnt", 32'(done_cnt - d0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
